// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-port ALU sharing arbiter.
// Op-code values mirror the ALU control decoder's Operation encoding.
package alu_share_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } owner_t;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0100;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] OP_SLT = 4'b1110;

  function automatic owner_t to_owner(input logic sel);
    return sel ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is accepted.
// Generic so it can front any future shared resource.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       last_grant
);

  // On contention the port that did not win last time is preferred.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// branch/address unit (port 1) through an issue register and per-port response registers.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,

  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  logic              s1_valid;
  logic [OP_W-1:0]   s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  owner_t            s1_owner;

  logic [1:0]        grant;
  logic              last_grant;
  logic              accept;
  logic              dst_free;
  logic              advance;
  logic              s1_free;
  logic              wr0;
  logic              wr1;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({req1_valid, req0_valid}),
    .accept     (accept),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // S1 only loads on an accept, which is also the only time the pointer moves,
  // so the pointer always names the owner of the operation sitting in S1.
  assign s1_owner = to_owner(last_grant);

  always_comb begin
    dst_free = 1'b0;
    if (s1_owner == PORT1) begin
      dst_free = !rsp1_valid || rsp1_ready;
    end else begin
      dst_free = !rsp0_valid || rsp0_ready;
    end
  end

  assign advance = s1_valid && dst_free;
  assign s1_free = !s1_valid || advance;
  assign wr0     = advance && (s1_owner == PORT0);
  assign wr1     = advance && (s1_owner == PORT1);

  assign req0_ready = s1_free && grant[0] && !reset;
  assign req1_ready = s1_free && grant[1] && !reset;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= grant[1] ? req1_op : req0_op;
      s1_a     <= grant[1] ? req1_a  : req0_a;
      s1_b     <= grant[1] ? req1_b  : req0_b;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // The ALU sees zeros whenever no operation is in flight.
  assign alu_op = s1_valid ? s1_op : '0;
  assign alu_a  = s1_valid ? s1_a  : '0;
  assign alu_b  = s1_valid ? s1_b  : '0;

  // A write wins over a same-cycle drain, so a streaming port sees no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
    end else if (wr0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_result;
      rsp0_zero   <= alu_zero;
    end else if (rsp0_valid && rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else if (wr1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_result;
      rsp1_zero   <= alu_zero;
    end else if (rsp1_valid && rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

endmodule
